ultrasonic_trig_seq: RTL and testbench

Multi-channel trigger sequencer for the car's ultrasonic ranging array. It drives one transducer trigger at a time in round-robin over the enabled channels. Pulse width is set at elaboration, and the per-channel slot length is set at run time. It supports single-sweep and continuous modes. All timing counts a 1 µs tick enable, so the block runs on the fabric clock. It sits between the ultrasonic control registers and the per-channel echo timers; `slot_start` and `active_ch` tell the echo timers which channel to time.

---
 rtl/ultrasonic_pkg.sv | 23 ++
 rtl/ultrasonic_ch_pick.sv | 33 +++
 rtl/ultrasonic_trig_seq.sv | 186 ++++++++++++++++++
 tb/tb_ultrasonic_trig_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_pkg.sv
// ultrasonic_pkg: shared types and helpers for the ultrasonic trigger sequencer
// and the echo timer blocks.
package ultrasonic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } seq_state_t;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Effective slot length: a slot must always be longer than the pulse so
  // that every trigger has at least one tick of low time before the next.
  function automatic logic [31:0] slot_clamp(input logic [31:0] slot_len,
                                             input logic [31:0] pulse_len);
    return (slot_len > pulse_len) ? slot_len : (pulse_len + 32'd1);
  endfunction

endpackage

// File: rtl/ultrasonic_ch_pick.sv
// ultrasonic_ch_pick: combinational priority finder over a channel mask.
// Returns the next set bit strictly above cur_idx (with a found flag) and the
// lowest set bit of the mask.
module ultrasonic_ch_pick
  import ultrasonic_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = ch_width(N_CH)
) (
  input  logic [N_CH-1:0] mask,
  input  logic [CH_W-1:0] cur_idx,
  output logic [CH_W-1:0] next_idx,
  output logic            next_found,
  output logic [CH_W-1:0] low_idx
);

  // Scan from the top down so the lowest qualifying bit is the last one written.
  always_comb begin
    next_idx   = '0;
    next_found = 1'b0;
    low_idx    = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low_idx = CH_W'(i);
        if (i > int'(cur_idx)) begin
          next_idx   = CH_W'(i);
          next_found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ultrasonic_trig_seq.sv
// ultrasonic_trig_seq: round-robin trigger sequencer for the ultrasonic
// ranging array. One trigger at a time, PULSE_LEN ticks high, one slot per
// enabled channel, single-sweep or continuous operation.
module ultrasonic_trig_seq
  import ultrasonic_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int CH_W      = ch_width(N_CH),
  parameter int PULSE_LEN = 10,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [N_CH-1:0]  ch_mask,
  input  logic [CNT_W-1:0] slot_len,
  output logic [N_CH-1:0]  trig,
  output logic             triging,
  output logic [CH_W-1:0]  active_ch,
  output logic             slot_start,
  output logic             busy,
  output logic             sweep_done
);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);

  seq_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] slot_eff_q, slot_eff_d, slot_eff_new;
  logic [N_CH-1:0]  mask_q, mask_d, trig_d;
  logic             start_pend, start_pend_d;
  logic             stop_pend, stop_pend_d;
  logic [CH_W-1:0]  active_d;
  logic             triging_d, slot_start_d, busy_d, sweep_done_d;
  logic             launch;

  logic [CH_W-1:0]  next_idx, low_idx;
  logic             next_found;
  logic [CH_W-1:0]  next_low_unused, low_next_unused;
  logic             low_found_unused;

  assign slot_eff_new = CNT_W'(slot_clamp(32'(slot_len), 32'(PULSE_LEN)));

  // Next channel within the sweep comes from the latched mask.
  ultrasonic_ch_pick #(.N_CH(N_CH), .CH_W(CH_W)) u_next_pick (
    .mask       (mask_q),
    .cur_idx    (active_ch),
    .next_idx   (next_idx),
    .next_found (next_found),
    .low_idx    (next_low_unused)
  );

  // First channel of a new sweep comes from the live mask being latched.
  ultrasonic_ch_pick #(.N_CH(N_CH), .CH_W(CH_W)) u_low_pick (
    .mask       (ch_mask),
    .cur_idx    ({CH_W{1'b0}}),
    .next_idx   (low_next_unused),
    .next_found (low_found_unused),
    .low_idx    (low_idx)
  );

  // Next-state and next-output logic; a sweep launch (from IDLE or a
  // continuous-mode wrap) is folded into one common block at the end.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    mask_d       = mask_q;
    slot_eff_d   = slot_eff_q;
    start_pend_d = start_pend;
    stop_pend_d  = stop_pend;
    trig_d       = trig;
    active_d     = active_ch;
    slot_start_d = 1'b0;
    sweep_done_d = 1'b0;
    launch       = 1'b0;

    case (state)
      IDLE: begin
        if (stop) begin
          start_pend_d = 1'b0;
        end else if (start && (|ch_mask)) begin
          start_pend_d = 1'b1;
        end
        if (tick && start_pend_d) begin
          if (|ch_mask) begin
            launch = 1'b1;
          end else begin
            start_pend_d = 1'b0;
          end
        end
      end

      PULSE: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (tick) begin
          cnt_d = cnt + CNT_ONE;
          if (cnt == PULSE_LAST) begin
            trig_d  = '0;
            state_d = GAP;
          end
        end
      end

      GAP: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (tick) begin
          cnt_d = cnt + CNT_ONE;
          if (cnt == (slot_eff_q - CNT_ONE)) begin
            cnt_d = '0;
            if (next_found) begin
              state_d      = PULSE;
              active_d     = next_idx;
              trig_d       = N_CH'(1) << next_idx;
              slot_start_d = 1'b1;
            end else begin
              sweep_done_d = 1'b1;
              state_d      = IDLE;
              if (mode && !stop_pend_d && (|ch_mask)) begin
                launch = 1'b1;
              end
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (launch) begin
      mask_d       = ch_mask;
      slot_eff_d   = slot_eff_new;
      start_pend_d = 1'b0;
      stop_pend_d  = 1'b0;
      active_d     = low_idx;
      trig_d       = N_CH'(1) << low_idx;
      cnt_d        = '0;
      state_d      = PULSE;
      slot_start_d = 1'b1;
    end

    busy_d    = (state_d != IDLE);
    triging_d = |trig_d;
  end

  // State, counters and every output are registered; reset is immediate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mask_q     <= '0;
      slot_eff_q <= '0;
      start_pend <= 1'b0;
      stop_pend  <= 1'b0;
      trig       <= '0;
      triging    <= 1'b0;
      active_ch  <= '0;
      slot_start <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      mask_q     <= mask_d;
      slot_eff_q <= slot_eff_d;
      start_pend <= start_pend_d;
      stop_pend  <= stop_pend_d;
      trig       <= trig_d;
      triging    <= triging_d;
      active_ch  <= active_d;
      slot_start <= slot_start_d;
      busy       <= busy_d;
      sweep_done <= sweep_done_d;
    end
  end

endmodule

// File: tb/tb_ultrasonic_trig_seq.sv
// tb_ultrasonic_trig_seq: directed bench for the ultrasonic trigger sequencer.
// N_CH=4, PULSE_LEN=10, tick every 4 clk, so one tick period is 4 clk.
module tb_ultrasonic_trig_seq;

  logic        clk;
  logic        rst;
  logic        tick;
  logic        start;
  logic        stop;
  logic        mode;
  logic [3:0]  ch_mask;
  logic [15:0] slot_len;
  logic [3:0]  trig;
  logic        triging;
  logic [1:0]  active_ch;
  logic        slot_start;
  logic        busy;
  logic        sweep_done;

  int vectors;
  int miscompares;

  int cyc;
  int rise_tm[$];
  int rise_ch[$];
  int fall_tm[4];
  int ss_cnt, sd_cnt, sd_tm, both_cnt, busy_fall_tm;
  logic [3:0] trig_prev;
  logic       busy_prev;
  int c0;

  ultrasonic_trig_seq #(
    .N_CH(4), .CH_W(2), .PULSE_LEN(10), .CNT_W(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .ch_mask    (ch_mask),
    .slot_len   (slot_len),
    .trig       (trig),
    .triging    (triging),
    .active_ch  (active_ch),
    .slot_start (slot_start),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  // Free-running fabric clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 1 us timebase: one clk-wide enable on every fourth rising edge.
  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  // Event log sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (trig[i] && !trig_prev[i]) begin
        rise_tm.push_back(cyc);
        rise_ch.push_back(i);
      end
      if (!trig[i] && trig_prev[i]) fall_tm[i] = cyc;
    end
    if (slot_start) ss_cnt++;
    if (sweep_done) begin
      sd_cnt++;
      sd_tm = cyc;
    end
    if (slot_start && sweep_done) both_cnt++;
    if (busy_prev && !busy) busy_fall_tm = cyc;
    trig_prev = trig;
    busy_prev = busy;
  end

  function automatic int rt(input int k);
    return (k < rise_tm.size()) ? rise_tm[k] : -1;
  endfunction

  function automatic int rc(input int k);
    return (k < rise_ch.size()) ? rise_ch[k] : -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clearLog();
    rise_tm.delete();
    rise_ch.delete();
    for (int i = 0; i < 4; i++) fall_tm[i] = -1;
    ss_cnt       = 0;
    sd_cnt       = 0;
    sd_tm        = -1;
    both_cnt     = 0;
    busy_fall_tm = -1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Sets up a sweep request and pulses start, either on a tick edge or on
  // the edge right after one; returns the cycle count after the start edge.
  task automatic applyStimulus(input logic [3:0] mask, input logic [15:0] slot,
                               input logic md, input logic coincident,
                               output int start_cyc);
    ch_mask  = mask;
    slot_len = slot;
    mode     = md;
    for (int i = 0; i < 8 && tick !== 1'b1; i++) step();
    if (coincident) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end else begin
      step();
      start = 1'b1;
      step();
      start = 1'b0;
    end
    start_cyc = cyc;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
    ch_mask = 4'b0000; slot_len = 16'd0;
    vectors = 0; miscompares = 0; cyc = 0;
    trig_prev = 4'b0000; busy_prev = 1'b0;
    clearLog();

    repeat (3) step();
    checkOutput("reset_trig", int'(trig), 0);
    checkOutput("reset_triging", int'(triging), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_active_ch", int'(active_ch), 0);
    checkOutput("reset_slot_start", int'(slot_start), 0);
    checkOutput("reset_sweep_done", int'(sweep_done), 0);
    rst = 1'b0;
    repeat (2) step();

    // Single sweep over ch0, ch1, ch3 with a start coincident with tick.
    $display("[TB] single sweep");
    clearLog();
    applyStimulus(4'b1011, 16'd60, 1'b0, 1'b1, c0);
    checkOutput("s1_trig_on_start_edge", int'(trig), 1);
    checkOutput("s1_slot_start", int'(slot_start), 1);
    checkOutput("s1_busy", int'(busy), 1);
    checkOutput("s1_triging", int'(triging), 1);
    repeat (100) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (700) step();
    checkOutput("s1_rise_count", rise_ch.size(), 3);
    checkOutput("s1_ch_a", rc(0), 0);
    checkOutput("s1_ch_b", rc(1), 1);
    checkOutput("s1_ch_c", rc(2), 3);
    checkOutput("s1_pulse_width", fall_tm[0] - rt(0), 40);
    checkOutput("s1_spacing_01", rt(1) - rt(0), 240);
    checkOutput("s1_spacing_13", rt(2) - rt(1), 240);
    checkOutput("s1_done_delay", sd_tm - rt(2), 240);
    checkOutput("s1_busy_fall", busy_fall_tm - rt(2), 240);
    checkOutput("s1_slot_starts", ss_cnt, 3);
    checkOutput("s1_done_count", sd_cnt, 1);
    checkOutput("s1_idle_busy", int'(busy), 0);
    checkOutput("s1_idle_trig", int'(trig), 0);
    checkOutput("s1_active_hold", int'(active_ch), 3);

    // Continuous sweep of ch1/ch2, stop requested during the second ch1 slot.
    $display("[TB] continuous with stop");
    clearLog();
    applyStimulus(4'b0110, 16'd60, 1'b1, 1'b0, c0);
    checkOutput("s2_no_early_trig", int'(trig), 0);
    repeat (597) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (500) step();
    mode = 1'b0;
    checkOutput("s2_start_latency", rt(0) - c0, 4);
    checkOutput("s2_rise_count", rise_ch.size(), 4);
    checkOutput("s2_ch_a", rc(0), 1);
    checkOutput("s2_ch_b", rc(1), 2);
    checkOutput("s2_ch_c", rc(2), 1);
    checkOutput("s2_ch_d", rc(3), 2);
    checkOutput("s2_spacing_a", rt(1) - rt(0), 240);
    checkOutput("s2_spacing_wrap", rt(2) - rt(1), 240);
    checkOutput("s2_spacing_c", rt(3) - rt(2), 240);
    checkOutput("s2_last_done", sd_tm - rt(3), 240);
    checkOutput("s2_done_count", sd_cnt, 2);
    checkOutput("s2_done_with_start", both_cnt, 1);
    checkOutput("s2_slot_starts", ss_cnt, 4);
    checkOutput("s2_idle_busy", int'(busy), 0);

    // Clamp: slot_len below the pulse gives an 11-tick slot.
    $display("[TB] slot clamp and empty mask");
    clearLog();
    applyStimulus(4'b0011, 16'd5, 1'b0, 1'b1, c0);
    repeat (150) step();
    checkOutput("s3_rise_count", rise_ch.size(), 2);
    checkOutput("s3_spacing", rt(1) - rt(0), 44);
    checkOutput("s3_pulse_width", fall_tm[0] - rt(0), 40);
    checkOutput("s3_done_delay", sd_tm - rt(1), 44);
    checkOutput("s3_idle_busy", int'(busy), 0);
    clearLog();
    applyStimulus(4'b0000, 16'd60, 1'b0, 1'b1, c0);
    checkOutput("s3_zero_mask_busy", int'(busy), 0);
    repeat (20) step();
    checkOutput("s3_zero_mask_trig", int'(trig), 0);
    checkOutput("s3_zero_mask_busy_late", int'(busy), 0);
    checkOutput("s3_zero_mask_slots", ss_cnt, 0);

    // Mask narrowed during ch0's slot: this sweep keeps all four channels.
    $display("[TB] mask change mid-sweep");
    clearLog();
    applyStimulus(4'b1111, 16'd20, 1'b1, 1'b1, c0);
    repeat (20) step();
    ch_mask = 4'b0001;
    repeat (330) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (200) step();
    mode = 1'b0;
    checkOutput("s4_rise_count", rise_ch.size(), 5);
    checkOutput("s4_ch_a", rc(0), 0);
    checkOutput("s4_ch_b", rc(1), 1);
    checkOutput("s4_ch_c", rc(2), 2);
    checkOutput("s4_ch_d", rc(3), 3);
    checkOutput("s4_ch_e", rc(4), 0);
    checkOutput("s4_spacing", rt(1) - rt(0), 80);
    checkOutput("s4_spacing_wrap", rt(4) - rt(3), 80);
    checkOutput("s4_last_done", sd_tm - rt(4), 80);
    checkOutput("s4_done_count", sd_cnt, 2);
    checkOutput("s4_slot_starts", ss_cnt, 5);
    checkOutput("s4_idle_busy", int'(busy), 0);

    // Asynchronous reset during ch2's pulse, then a fresh sweep from ch0.
    $display("[TB] async reset mid-pulse");
    clearLog();
    applyStimulus(4'b0100, 16'd60, 1'b0, 1'b1, c0);
    repeat (20) step();
    checkOutput("s5_pre_trig", int'(trig), 4);
    checkOutput("s5_pre_active", int'(active_ch), 2);
    rst = 1'b1;
    #1;
    checkOutput("s5_rst_trig", int'(trig), 0);
    checkOutput("s5_rst_triging", int'(triging), 0);
    checkOutput("s5_rst_busy", int'(busy), 0);
    checkOutput("s5_rst_active", int'(active_ch), 0);
    checkOutput("s5_rst_slot_start", int'(slot_start), 0);
    checkOutput("s5_rst_sweep_done", int'(sweep_done), 0);
    repeat (3) step();
    rst = 1'b0;
    step();
    clearLog();
    applyStimulus(4'b0101, 16'd60, 1'b0, 1'b1, c0);
    checkOutput("s5_fresh_trig", int'(trig), 1);
    checkOutput("s5_fresh_active", int'(active_ch), 0);
    checkOutput("s5_fresh_slot_start", int'(slot_start), 1);
    repeat (500) step();
    checkOutput("s5_fresh_rises", rise_ch.size(), 2);
    checkOutput("s5_fresh_second_ch", rc(1), 2);
    checkOutput("s5_fresh_done", sd_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
